// File: rtl/sll_seq_shifter.sv
// Iterative logical-left shifter: resolves one shift-amount bit per clock
// (SHW stages), with valid/ready handshakes on request and result.
module sll_seq_shifter #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_data,
  input  logic [SHW-1:0]  i_shamt,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic [1:0]      o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a held result stays stable.

  localparam int CW = $clog2(SHW + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] data_reg, data_n;
  logic [SHW-1:0]  shamt_reg, shamt_n;
  logic [SHW-1:0]  stage_mask;
  logic [CW-1:0]   cnt, cnt_n;

  // Weight of the current stage (1 << cnt) doubles as the shift distance.
  assign stage_mask = SHW'(1) << cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      data_reg  <= '0;
      shamt_reg <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      data_reg  <= data_n;
      shamt_reg <= shamt_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_reg;
    shamt_n = shamt_reg;
    cnt_n   = cnt;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          data_n  = i_data;
          shamt_n = i_shamt;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        o_busy = 1'b1;
        if (|(shamt_reg & stage_mask)) begin
          data_n = data_reg << stage_mask;
        end
        cnt_n = cnt + CW'(1);
        // Fixed SHW-cycle walk, even when the shift amount is zero.
        if (cnt == CW'(SHW - 1)) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign o_result    = data_reg;
  assign o_dbg_state = state;

endmodule
